// File: rtl/demux_8x4_sequencial_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Shared definitions for the registered 1-to-8 demultiplexer.
//   N_CH        : number of output channels
//   SEL_W       : width of a channel index
//   chan_idx_t  : channel index type
//   modo_t      : selection mode (explicit select or auto-scan)
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] chan_idx_t;

    typedef enum logic {
        MODO_EXPLICITO = 1'b0,
        MODO_VARREDURA = 1'b1
    } modo_t;

endpackage : demux_pkg

// File: rtl/demux_8x4_sequencial_if.sv
// -----------------------------------------------------------------------------
// demux_8x4_sequencial_if
//   Bus bundle between a word source and the demultiplexer.
//   Source side : in_valid, in_data, modo, seletor
//   Sink side   : out0..out7, out_valid, scan_idx, frame_done, frame_count
//
//   Handshake: in_valid alone qualifies in_data/modo/seletor at a rising
//   clk edge. There is no ready; the demux accepts every valid word, so the
//   source never stalls. out_valid[k] is a one-cycle strobe marking the
//   cycle in which outk holds a newly written word.
//
//   master : the word source (drives inputs, observes outputs)
//   slave  : the demultiplexer
// -----------------------------------------------------------------------------
interface demux_8x4_sequencial_if #(
    parameter int WIDTH = 4
);
    import demux_pkg::*;

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             modo;
    chan_idx_t        seletor;

    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out5;
    logic [WIDTH-1:0] out6;
    logic [WIDTH-1:0] out7;
    logic [N_CH-1:0]  out_valid;
    chan_idx_t        scan_idx;
    logic             frame_done;
    logic [7:0]       frame_count;

    modport master (
        output in_valid, in_data, modo, seletor,
        input  out0, out1, out2, out3, out4, out5, out6, out7,
        input  out_valid, scan_idx, frame_done, frame_count
    );

    modport slave (
        input  in_valid, in_data, modo, seletor,
        output out0, out1, out2, out3, out4, out5, out6, out7,
        output out_valid, scan_idx, frame_done, frame_count
    );

endinterface : demux_8x4_sequencial_if

// File: rtl/demux_8x4_sequencial_contador_varredura.sv
// -----------------------------------------------------------------------------
// contador_varredura
//   Auto-scan channel counter: counts 0..7 and wraps.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to 0 (priority over enable)
//   enable     : advance by one at this edge
//   count      : current count (next channel to be written)
//   wrap       : high when count = 7 and enable = 1 (this edge ends a frame)
// -----------------------------------------------------------------------------
module contador_varredura
    import demux_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clear,
    input  logic      enable,
    output chan_idx_t count,
    output logic      wrap
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            // Natural 3-bit overflow gives the 7 -> 0 wrap.
            count <= count + 1'b1;
        end
    end

    assign wrap = enable && (count == chan_idx_t'(N_CH - 1));

endmodule : contador_varredura

// File: rtl/demux_8x4_sequencial.sv
// -----------------------------------------------------------------------------
// demux_8x4_sequencial
//   Registered 1-to-8 demultiplexer. Each accepted word is written into one
//   held output channel, chosen either by seletor (explicit mode) or by an
//   internal auto-scan counter that fills channels 0..7 in order and pulses
//   frame_done after channel 7.
//
//   Ports
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     clear : synchronous clear of channels, scan counter, strobes and count
//     bus   : slave side of demux_8x4_sequencial_if (data in, channels out)
//
//   Optional build macro DEMUX_FRAME_COUNT_EN: when defined, frame_count
//   counts completed auto-scan frames (wraps 255 -> 0); otherwise it is tied
//   to 0 and no counter register exists.
// -----------------------------------------------------------------------------
module demux_8x4_sequencial
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    demux_8x4_sequencial_if.slave   bus
);

    logic [WIDTH-1:0] chan_q [N_CH];
    logic [N_CH-1:0]  out_valid_q;
    logic             frame_done_q;
    chan_idx_t        scan_idx;
    logic             scan_wrap;
    logic             scan_en;
    chan_idx_t        wr_idx;
    modo_t            modo;

    assign modo    = modo_t'(bus.modo);
    assign scan_en = bus.in_valid && (modo == MODO_VARREDURA);
    // seletor only matters in explicit mode; auto-scan writes the held index.
    assign wr_idx  = (modo == MODO_VARREDURA) ? scan_idx : bus.seletor;

    contador_varredura u_contador (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .enable (scan_en),
        .count  (scan_idx),
        .wrap   (scan_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) chan_q[k] <= '0;
            out_valid_q  <= '0;
            frame_done_q <= 1'b0;
        end else if (clear) begin
            // clear wins over a simultaneous word: it is dropped, no strobe.
            for (int k = 0; k < N_CH; k++) chan_q[k] <= '0;
            out_valid_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= '0;
            frame_done_q <= 1'b0;
            if (bus.in_valid) begin
                chan_q[wr_idx] <= bus.in_data;
                out_valid_q    <= {{(N_CH-1){1'b0}}, 1'b1} << wr_idx;
                frame_done_q   <= scan_wrap;
            end
        end
    end

`ifdef DEMUX_FRAME_COUNT_EN
    logic [7:0] frame_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_q <= '0;
        end else if (clear) begin
            frame_count_q <= '0;
        end else if (scan_wrap) begin
            // Same edge that launches frame_done; 8-bit overflow wraps 255 -> 0.
            frame_count_q <= frame_count_q + 8'd1;
        end
    end

    assign bus.frame_count = frame_count_q;
`else
    assign bus.frame_count = 8'd0;
`endif

    assign bus.out0       = chan_q[0];
    assign bus.out1       = chan_q[1];
    assign bus.out2       = chan_q[2];
    assign bus.out3       = chan_q[3];
    assign bus.out4       = chan_q[4];
    assign bus.out5       = chan_q[5];
    assign bus.out6       = chan_q[6];
    assign bus.out7       = chan_q[7];
    assign bus.out_valid  = out_valid_q;
    assign bus.scan_idx   = scan_idx;
    assign bus.frame_done = frame_done_q;

endmodule : demux_8x4_sequencial
